// File: rtl/encoder_8_to_3_seq_if.sv
// encoder_8_to_3_seq_if: request/offer/ack bundle between event sources, the encoder and its consumer
interface encoder_8_to_3_seq_if;
    logic [7:0] req_i;
    logic       ack_i;
    logic [2:0] code_o;
    logic       valid_o;
    logic [7:0] pending_o;
    logic       multi_o;

    modport master (
        output req_i, ack_i,
        input  code_o, valid_o, pending_o, multi_o
    );

    modport slave (
        input  req_i, ack_i,
        output code_o, valid_o, pending_o, multi_o
    );
endinterface

// File: rtl/encoder_8_to_3_seq.sv
// encoder_8_to_3_seq: registered 8-to-3 priority encoder with sticky pending bits and a valid/ack offer
// Optional rotating priority is enabled by defining ENCODER_ROUND_ROBIN_EN; default is fixed priority (bit 7 highest).
module encoder_8_to_3_seq (
    input  logic                       clk,
    input  logic                       rst_n,
    encoder_8_to_3_seq_if.slave        bus
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_pending, w_pending_next, w_clear;
    logic [2:0] r_code, w_code_next, w_ptr, w_sel, w_idx;
    logic       r_multi, w_found, w_ack;

    assign w_ack          = (r_state == OFFER) && bus.ack_i;
    assign w_clear        = w_ack ? (8'b1 << r_code) : 8'h00;
    assign w_pending_next = (r_pending & ~w_clear) | bus.req_i;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [2:0] r_ptr;

    // Restart the search just below the acknowledged index so busy high bits cannot starve low ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= 3'd7;
        else if (w_ack) r_ptr <= r_code - 3'd1;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 3'd7;
`endif

    // Descend from the pointer with wraparound; the first pending index found is selected
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx = w_ptr - 3'(i);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Latch a code when idle and something is pending; hold it untouched until acknowledged
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        if (r_state == IDLE && w_found) begin
            w_state_next = OFFER;
            w_code_next  = w_sel;
        end else if (w_ack) begin
            w_state_next = IDLE;
        end
    end

    // State, offered code, pending set, and the more-than-one-pending flag of the next pending value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_code    <= 3'd0;
            r_pending <= 8'h00;
            r_multi   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_code    <= w_code_next;
            r_pending <= w_pending_next;
            r_multi   <= (w_pending_next & (w_pending_next - 8'd1)) != 8'h00;
        end
    end

    assign bus.code_o    = r_code;
    assign bus.valid_o   = (r_state == OFFER);
    assign bus.pending_o = r_pending;
    assign bus.multi_o   = r_multi;
endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// tb_encoder_8_to_3_seq: scoreboard bench with a set-based reference model for the 8-to-3 encoder
module tb_encoder_8_to_3_seq;
    typedef struct {
        logic [7:0] pend;
        logic       valid;
        logic       multi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    exp_t q_cyc[$];
    int   q_off[$];

    logic [7:0] m_pend = 8'h00;
    bit         m_busy = 1'b0;
    int         m_code = 0;
    int         m_ptr = 7;

    bit         prev_valid = 1'b0;
    logic [2:0] prev_code = 3'd0;

    encoder_8_to_3_seq_if bus ();

    encoder_8_to_3_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] p, input int ptr);
        for (int j = 0; j < 8; j++) begin
            int k = (ptr - j + 8) % 8;
            if (p[k]) return k;
        end
        return 0;
    endfunction

    function automatic int ones(input logic [7:0] p);
        int n = 0;
        for (int j = 0; j < 8; j++) n += p[j];
        return n;
    endfunction

    task automatic model_step(input logic [7:0] r, input bit a);
        logic [7:0] old = m_pend;
        bit acc = m_busy && a;
        m_pend = (old & ~(acc ? (8'b1 << m_code) : 8'h00)) | r;
        if (acc) begin
            m_busy = 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
            m_ptr = (m_code + 7) % 8;
`endif
        end else if (!m_busy && old != 8'h00) begin
            m_busy = 1'b1;
            m_code = pick(old, m_ptr);
            q_off.push_back(m_code);
        end
        q_cyc.push_back('{pend: m_pend, valid: m_busy, multi: ones(m_pend) > 1});
    endtask

    task automatic cyc(input logic [7:0] r, input bit a);
        bus.req_i = r;
        bus.ack_i = a;
        @(posedge clk);
        model_step(r, a);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (m_busy || m_pend != 8'h00); n++) cyc(8'h00, m_busy);
        chk("drain_done", int'(m_busy || m_pend != 8'h00), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && run) begin
                if (q_cyc.size() != 0) begin
                    e = q_cyc.pop_front();
                    chk("pending", int'(bus.pending_o), int'(e.pend));
                    chk("valid", int'(bus.valid_o), int'(e.valid));
                    chk("multi", int'(bus.multi_o), int'(e.multi));
                end
                if (bus.valid_o && !prev_valid) begin
                    if (q_off.size() == 0) chk("unexpected_offer", int'(bus.code_o), -1);
                    else chk("offer_code", int'(bus.code_o), q_off.pop_front());
                end
                if (bus.valid_o && prev_valid) chk("code_stable", int'(bus.code_o), int'(prev_code));
                prev_valid = bus.valid_o;
                prev_code  = bus.code_o;
            end
        end
    endtask

    task automatic model_reset();
        q_cyc.delete();
        q_off.delete();
        m_pend = 8'h00;
        m_busy = 1'b0;
        m_ptr = 7;
        prev_valid = 1'b0;
    endtask

    initial begin
        bus.req_i = 8'h00;
        bus.ack_i = 1'b0;
        fork
            monitor();
        join_none
        #1;
        chk("rst_pending", int'(bus.pending_o), 0);
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_code", int'(bus.code_o), 0);
        chk("rst_multi", int'(bus.multi_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b1;

        cyc(8'h04, 0); cyc(8'h00, 0); cyc(8'h00, 0); cyc(8'h00, 1); cyc(8'h00, 0);

        cyc(8'h92, 0);
        for (int n = 0; n < 12; n++) cyc(8'h00, m_busy);
        drain();

        cyc(8'h08, 0); cyc(8'h00, 0); cyc(8'h40, 0); cyc(8'h00, 0); cyc(8'h00, 1);
        drain();

        cyc(8'h04, 0); cyc(8'h00, 0); cyc(8'h04, 1); cyc(8'h00, 0); cyc(8'h00, 0);
        drain();

        cyc(8'hFF, 0);
        for (int n = 0; n < 24; n++) cyc(8'hC0, m_busy);
        drain();

        cyc(8'h20, 0); cyc(8'h00, 0); cyc(8'h00, 0);
        chk("pre_rst_code", int'(bus.code_o), 5);
        #2;
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_pending", int'(bus.pending_o), 0);
        chk("arst_valid", int'(bus.valid_o), 0);
        chk("arst_code", int'(bus.code_o), 0);
        chk("arst_multi", int'(bus.multi_o), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b1;
        for (int n = 0; n < 4; n++) cyc(8'h00, 0);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cyc(r, m_busy && ($urandom_range(0, 2) != 0));
        end
        drain();
        cyc(8'h00, 0);
        @(negedge clk);
        #1;
        chk("offers_left", q_off.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/encoder_8_to_3_seq.md
# encoder_8_to_3_seq

Registered 8-to-3 priority encoder with request latching and a valid/ack handshake, the encode-side counterpart to the 3-to-8 decoder. Eight request lines set sticky pending bits. The block offers the 3-bit index of one pending request, holds it stable until it is acknowledged, then clears that bit. It sits between event sources (interrupt or select lines) and a consumer that services one index at a time.

## Interface
- No parameters. Widths are fixed: 8 requests, 3-bit code.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_i  input  8  request lines; any bit high at a clk edge sets the matching pending bit
- ack_i  input  1  consumer accepts the offered code; sampled only while valid_o=1
- code_o  output  3  index of the offered request; registered
- valid_o  output  1  code_o is valid and being offered; registered
- pending_o  output  8  current pending register
- multi_o  output  1  registered; 1 when more than one pending bit is set

## Operation
- Reset (rst_n=0, asynchronous): pending_o=8'h00, code_o=3'b000, valid_o=0, multi_o=0, state=IDLE, RR pointer=7.
- Pending update at each edge: pending_next = (pending & ~clear_mask) | req_i.
  - clear_mask is one-hot at code_o when valid_o && ack_i, else 0.
  - A set and a clear on the same bit in the same cycle: set wins, and the bit stays pending.
- State machine, two states:
  - IDLE: if pending != 0 at the edge, load code_o with the selected index, set valid_o=1, go to OFFER. Otherwise stay, with valid_o=0.
  - OFFER: code_o and valid_o are held. New requests, including higher-priority ones, do not change code_o. On ack_i=1: clear pending[code_o], set valid_o=0, go to IDLE. On ack_i=0: stay.
- Selection, fixed priority: the highest set index wins (bit 7 highest, bit 0 lowest).
- ack_i while in IDLE is ignored and changes no state.
- multi_o = popcount(pending_next) > 1, registered.
- Mid-operation reset: everything returns to reset values immediately. A pending request that is not re-asserted after reset is lost.

## Timing
- req_i bit k high at edge N: pending_o[k]=1 after edge N.
- If idle, valid_o=1 with code_o=k after edge N+1. Request-to-offer latency is 2 cycles.
- ack_i=1 at edge M while valid_o=1: valid_o=0 and the pending bit is cleared after edge M.
- The earliest next offer is after edge M+1. Minimum spacing between offers is 2 cycles; one idle cycle between grants is mandatory.
- code_o is stable for the whole time valid_o=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. The search for the selected index starts at the RR pointer and descends with wrap (ptr, ptr-1, …, 0, 7, …).
  - After an ack of code k, the pointer becomes (k-1) mod 8, so k=0 wraps the pointer to 7.
  - The pointer resets to 7, so the first grant after reset matches fixed priority.
- Not defined: fixed priority as described in Operation. The pointer register is not built.

## Test plan
- Reset: drive rst_n=0 mid-offer (valid_o=1, code_o=5) -> all outputs go to zero and state returns to IDLE asynchronously. Nothing is offered after release until req_i is asserted again.
- Single request: req_i=8'b0000_0100 for one cycle -> pending_o=8'h04 next cycle, then valid_o=1 with code_o=2. Ack -> pending_o=8'h00, valid_o=0.
- Fixed priority: req_i=8'b1001_0010 in one cycle, ack every offer -> codes offered in order 7, 4, 1, each separated by one idle cycle. multi_o=1 until only one bit remains pending.
- Hold under preemption: code_o=3 offered with ack_i=0, then assert req_i[6] -> code_o stays 3 until ack. The next offer is 6.
- Set/clear collision: ack of code 2 in the same cycle that req_i[2]=1 -> pending_o[2] stays 1 and code 2 is re-offered after one idle cycle.
- ENCODER_ROUND_ROBIN_EN defined: hold req_i=8'hFF for one cycle, ack each offer while re-asserting req_i[7] and req_i[6] every cycle -> offers go 7, 6, 5, 4, 3, 2, 1, 0, 7, 6, so 7 and 6 do not starve the lower bits. The pointer wraps from 0 to 7.
